pkt_rr_mux: RTL
===============

PKT_RR_MUX -- requirements
Module: pkt_rr_mux

Interface
REQ-001 Parameter NPORT, default 4: number of input ports, 2..8.
REQ-002 Parameter PLW, default 64: payload width in bits.
REQ-003 Parameter VCHW, default 2: virtual-channel tag width in bits.
REQ-004 Derived FLITW = PLW+2; flit[FLITW-1:PLW] is the type: 00 NONE, 01 HEAD, 10 DATA, 11 TAIL.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_  in  1  reset, synchronous, active-low.
REQ-007 idata  in  NPORT*FLITW  input flits; port p occupies bits [p*FLITW +: FLITW].
REQ-008 ivalid  in  NPORT  per-port flit valid.
REQ-009 ivch  in  NPORT*VCHW  per-port VC tag; port p occupies bits [p*VCHW +: VCHW].
REQ-010 iready  out  NPORT  per-port accept; a flit transfers when ivalid[p] & iready[p].
REQ-011 odata  out  FLITW  registered output flit.
REQ-012 ovalid  out  1  registered output valid.
REQ-013 ovch  out  VCHW  registered output VC tag.
REQ-014 oready  in  1  downstream accept; an output transfers when ovalid & oready.
REQ-015 oerr  out  1  one-cycle pulse when a stray flit is dropped.

Function
REQ-016 FSM has two states: IDLE and LOCK; holds grant register g (log2 NPORT bits) and round-robin pointer ptr.
REQ-017 IDLE: eligible ports are those with ivalid=1 and type=HEAD; the grant goes to the first eligible port searching ptr+1, ptr+2, ... modulo NPORT.
REQ-018 IDLE with at least one eligible port: next cycle state=LOCK, g=winner; no flit is accepted in the arbitration cycle.
REQ-019 IDLE: iready=0 for eligible ports; iready=1 for valid non-HEAD ports, so stray DATA/TAIL/NONE flits are dropped and oerr pulses in the following cycle.
REQ-020 LOCK: iready[g] = !ovalid | oready; iready=0 for all other ports, which hold their flits.
REQ-021 LOCK, flit accepted from g: next cycle odata=idata_g, ovch=ivch_g, ovalid=1.
REQ-022 LOCK with no accept while ovalid & oready: next cycle ovalid=0; odata and ovch hold their values.
REQ-023 LOCK with ovalid & !oready: odata, ovalid and ovch hold; no accept occurs.
REQ-024 LOCK, accepted flit is TAIL: next cycle state=IDLE, ptr=g.
REQ-025 IDLE cannot grant again in the same cycle TAIL is accepted; minimum inter-packet gap on the output is 1 cycle.
REQ-026 LOCK, accepted flit is HEAD or NONE: forwarded unchanged and lock kept; only TAIL releases the lock.
REQ-027 Wormhole: a granted packet is never interleaved with flits from another port.
REQ-028 Latency: HEAD valid at cycle t in IDLE -> accepted at t+1 -> odata at t+2; each subsequent flit has 1-cycle latency; zero-bubble throughput while oready=1.
REQ-029 ivalid of the locked port dropping mid-packet: lock held indefinitely; no timeout.

Reset
REQ-030 rst_=0 at a rising edge: next cycle state=IDLE, ptr=NPORT-1 (port 0 has first priority), g=0, ovalid=0, odata=0, ovch=0, oerr=0.
REQ-031 iready=0 on all ports while rst_=0.
REQ-032 Reset asserted mid-packet discards the lock and the output flit; the remaining flits of that packet arrive as strays and follow REQ-019.

Verification (NPORT=4, PLW=64, VCHW=2)
REQ-033 Port1 sends HEAD(payload 0x4), 20 DATA, TAIL with oready=1 -> ovalid from cycle t+2 for 22 consecutive cycles; odata sequence identical; ovch=ivch_1; 1 idle cycle after TAIL.
REQ-034 Ports 0, 2 and 3 each present HEAD at the same cycle after reset -> packets output in order 0, 2, 3; a further port-0 HEAD presented during port-3's packet is served after port 3.
REQ-035 Port2 mid-packet, port0 HEAD waiting -> no port0 flit appears on odata until port2 TAIL is output; iready[0]=0 throughout.
REQ-036 oready held 0 for 5 cycles mid-packet -> odata and ovalid stable for those cycles, iready[g]=0; on release, flits resume with no loss or duplication.
REQ-037 DATA flit on port3 while IDLE -> iready[3]=1, flit dropped, oerr=1 for exactly 1 cycle, ovalid stays 0.
REQ-038 rst_=0 for 1 cycle mid-packet -> ovalid=0 next cycle; after release a port0 HEAD is granted before a simultaneous port1 HEAD.

Source files
------------

// File: rtl/pkt_rr_mux.sv
// pkt_rr_mux: wormhole round-robin packet mux; a HEAD wins the lock, only TAIL releases it.
module pkt_rr_mux #(
  parameter int NPORT = 4,
  parameter int PLW = 64,
  parameter int VCHW = 2
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic [NPORT*(PLW+2)-1:0]  idata,
  input  logic [NPORT-1:0]          ivalid,
  input  logic [NPORT*VCHW-1:0]     ivch,
  output logic [NPORT-1:0]          iready,
  output logic [PLW+1:0]            odata,
  output logic                      ovalid,
  output logic [VCHW-1:0]           ovch,
  input  logic                      oready,
  output logic                      oerr
);
  localparam int FLITW = PLW + 2;
  localparam int GW = $clog2(NPORT);
  typedef enum logic {S_IDLE, S_LOCK} state_t;
  state_t r_state, w_next;
  logic [GW-1:0] r_g, r_ptr, w_win;
  logic [FLITW-1:0] r_odata, w_gdata;
  logic [VCHW-1:0] r_ovch, w_gvch;
  logic r_ovalid, r_oerr, w_any, w_ok, w_acc, w_tail;
  logic [NPORT-1:0] w_head, w_stray;
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign w_head[p]  = ivalid[p] && idata[p*FLITW+PLW +: 2] == 2'b01;
    assign w_stray[p] = ivalid[p] && idata[p*FLITW+PLW +: 2] != 2'b01;
  end
  assign w_gdata = idata[r_g*FLITW +: FLITW];
  assign w_gvch  = ivch[r_g*VCHW +: VCHW];
  assign w_ok    = !r_ovalid || oready;
  assign w_acc   = r_state == S_LOCK && ivalid[r_g] && w_ok;
  assign w_tail  = w_gdata[FLITW-1:PLW] == 2'b11;
  // Scan downwards so the nearest eligible port after ptr is the last one written.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NPORT; i >= 1; i--) begin
      if (w_head[GW'((int'(r_ptr) + i) % NPORT)]) begin
        w_any = 1'b1;
        w_win = GW'((int'(r_ptr) + i) % NPORT);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_ptr   <= GW'(NPORT - 1);
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) r_g <= w_win;
      if (w_acc && w_tail) r_ptr <= r_g;
    end
  end
  always_comb begin
    w_next = r_state == S_IDLE ? (w_any ? S_LOCK : S_IDLE) : (w_acc && w_tail ? S_IDLE : S_LOCK);
  end
  always_comb begin
    iready = '0;
    if (rst_ && r_state == S_IDLE) iready = w_stray;
    else if (rst_) iready[r_g] = w_ok;
  end
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_odata  <= '0;
      r_ovch   <= '0;
      r_ovalid <= 1'b0;
      r_oerr   <= 1'b0;
    end else begin
      r_oerr   <= r_state == S_IDLE && |w_stray;
      r_ovalid <= w_acc || (r_ovalid && !oready);
      if (w_acc) begin
        r_odata <= w_gdata;
        r_ovch  <= w_gvch;
      end
    end
  end
  assign odata  = r_odata;
  assign ovch   = r_ovch;
  assign ovalid = r_ovalid;
  assign oerr   = r_oerr;
endmodule
